cpu_inta_sequencer: RTL and testbench

CPU_INTA_SEQUENCER -- requirements
Module: cpu_inta_sequencer

---
 rtl/cpu_inta_sequencer_pkg.sv | 23 ++
 rtl/cpu_inta_sequencer_if.sv | 43 ++++
 rtl/cpu_inta_sequencer_pulse_timer.sv | 28 ++
 rtl/cpu_inta_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_inta_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_inta_sequencer_pkg.sv
// Shared definitions for the CPU interrupt-acknowledge sequencer.
// Optional 8080/8085 CALL-mode support is enabled by INTA_MCS80_MODE_EN.
package inta_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK_LOW = 2'd1,
      ACK_GAP = 2'd2,
      HOLD    = 2'd3
   } inta_state_e;

   localparam logic [7:0]  CALL_OPCODE           = 8'hCD;
   localparam int unsigned INTA_PULSE_CYCLES_DEF = 32'd2;
   localparam int unsigned INTA_GAP_CYCLES_DEF   = 32'd1;
   localparam logic [1:0]  PULSES_8086           = 2'd2;
   localparam logic [1:0]  PULSES_MCS80          = 2'd3;

   // Timers count down to zero, so a phase of N clocks loads N-1.
   function automatic logic [3:0] timer_load(input int unsigned cycles);
      return 4'(cycles - 32'd1);
   endfunction

endpackage

// File: rtl/cpu_inta_sequencer_if.sv
// Handshake/bus bundle between the interrupt controller, the CPU and the
// acknowledge sequencer. mcs80_mode/call_address exist only when
// INTA_MCS80_MODE_EN is defined.
interface cpu_inta_sequencer_if;
   logic        interrupt_to_cpu;
   logic        cpu_interrupt_enable;
   logic [7:0]  data_bus_in;
   logic        data_bus_drive;
   logic        vector_taken;
   logic        interrupt_acknowledge_n;
   logic        bus_lock_n;
   logic        vector_valid;
   logic [7:0]  vector;
   logic        bus_error;
`ifdef INTA_MCS80_MODE_EN
   logic        mcs80_mode;
   logic [15:0] call_address;

   modport master (
      input  interrupt_to_cpu, cpu_interrupt_enable, data_bus_in, data_bus_drive,
             vector_taken, mcs80_mode,
      output interrupt_acknowledge_n, bus_lock_n, vector_valid, vector, bus_error,
             call_address
   );
   modport slave (
      output interrupt_to_cpu, cpu_interrupt_enable, data_bus_in, data_bus_drive,
             vector_taken, mcs80_mode,
      input  interrupt_acknowledge_n, bus_lock_n, vector_valid, vector, bus_error,
             call_address
   );
`else
   modport master (
      input  interrupt_to_cpu, cpu_interrupt_enable, data_bus_in, data_bus_drive,
             vector_taken,
      output interrupt_acknowledge_n, bus_lock_n, vector_valid, vector, bus_error
   );
   modport slave (
      output interrupt_to_cpu, cpu_interrupt_enable, data_bus_in, data_bus_drive,
             vector_taken,
      input  interrupt_acknowledge_n, bus_lock_n, vector_valid, vector, bus_error
   );
`endif
endinterface

// File: rtl/cpu_inta_sequencer_pulse_timer.sv
// Loadable 4-bit down-counter with a done flag; times both the low pulses
// and the high gaps. It saturates at zero instead of wrapping.
module inta_pulse_timer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic       decrement,
   input  logic [3:0] load_value,
   output logic       done
);
   logic [3:0] count_r;

   // Load has priority; otherwise count down and hold at zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= 4'd0;
      end else if (load) begin
         count_r <= load_value;
      end else if (decrement && (count_r != 4'd0)) begin
         count_r <= count_r - 4'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == 4'd0);

endmodule

// File: rtl/cpu_inta_sequencer.sv
// Interrupt-acknowledge sequencer: issues the INTA pulse train, holds the
// bus lock, captures the vector byte(s) and reports a non-driving controller.
// Define INTA_MCS80_MODE_EN to add the three-pulse CALL (8080/8085) mode.
module cpu_inta_sequencer
   import inta_pkg::*;
#(
   parameter int unsigned INTA_PULSE_CYCLES = INTA_PULSE_CYCLES_DEF,
   parameter int unsigned INTA_GAP_CYCLES   = INTA_GAP_CYCLES_DEF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   cpu_inta_sequencer_if.master bus
);
   localparam logic [3:0] PULSE_LOAD = timer_load(INTA_PULSE_CYCLES);
   localparam logic [3:0] GAP_LOAD   = timer_load(INTA_GAP_CYCLES);

   inta_state_e state_r;
   logic [1:0]  pulse_index_r;
   logic        ready_r;
   logic        inta_n_r;
   logic        lock_n_r;
   logic        valid_r;
   logic        error_r;
   logic [7:0]  vector_r;
`ifdef INTA_MCS80_MODE_EN
   logic        mode_r;
   logic [15:0] call_address_r;
`endif

   logic        accept_s;
   logic [1:0]  n_pulses_s;
   logic        last_pulse_s;
   logic        sample_pulse_s;
   logic        byte_bad_s;
   logic        sample_fail_s;
   logic        pulse_load_s;
   logic        pulse_dec_s;
   logic        gap_load_s;
   logic        gap_dec_s;
   logic        pulse_done_s;
   logic        gap_done_s;

   // Decide pulse count, which pulses carry data and whether the byte is bad.
   always_comb begin
      accept_s = ready_r & bus.interrupt_to_cpu & bus.cpu_interrupt_enable;
`ifdef INTA_MCS80_MODE_EN
      if (mode_r) begin
         n_pulses_s     = PULSES_MCS80;
         sample_pulse_s = 1'b1;
         byte_bad_s     = ~bus.data_bus_drive |
                          ((pulse_index_r == 2'd1) && (bus.data_bus_in != CALL_OPCODE));
      end else begin
         n_pulses_s     = PULSES_8086;
         sample_pulse_s = (pulse_index_r == 2'd2);
         byte_bad_s     = ~bus.data_bus_drive;
      end
`else
      n_pulses_s     = PULSES_8086;
      sample_pulse_s = (pulse_index_r == 2'd2);
      byte_bad_s     = ~bus.data_bus_drive;
`endif
      last_pulse_s  = (pulse_index_r == n_pulses_s);
      sample_fail_s = (state_r == ACK_LOW) & pulse_done_s & sample_pulse_s & byte_bad_s;
   end

   // Timer load/decrement strobes follow the phase the FSM is in.
   always_comb begin
      pulse_load_s = 1'b0;
      pulse_dec_s  = 1'b0;
      gap_load_s   = 1'b0;
      gap_dec_s    = 1'b0;
      case (state_r)
         IDLE:    pulse_load_s = accept_s;
         ACK_LOW: begin
            pulse_dec_s = 1'b1;
            gap_load_s  = pulse_done_s & ~last_pulse_s & ~sample_fail_s;
         end
         ACK_GAP: begin
            gap_dec_s    = 1'b1;
            pulse_load_s = gap_done_s;
         end
         default: pulse_load_s = 1'b0;
      endcase
   end

   inta_pulse_timer u_pulse_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (pulse_load_s),
      .decrement  (pulse_dec_s),
      .load_value (PULSE_LOAD),
      .done       (pulse_done_s)
   );

   inta_pulse_timer u_gap_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (gap_load_s),
      .decrement  (gap_dec_s),
      .load_value (GAP_LOAD),
      .done       (gap_done_s)
   );

   // Sequencer FSM with registered strobes; ready_r blocks acceptance on
   // the first edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= IDLE;
         pulse_index_r  <= 2'd0;
         ready_r        <= 1'b0;
         inta_n_r       <= 1'b1;
         lock_n_r       <= 1'b1;
         valid_r        <= 1'b0;
         error_r        <= 1'b0;
         vector_r       <= 8'h00;
`ifdef INTA_MCS80_MODE_EN
         mode_r         <= 1'b0;
         call_address_r <= 16'h0000;
`endif
      end else begin
         ready_r <= 1'b1;
         error_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r       <= ACK_LOW;
                  pulse_index_r <= 2'd1;
                  inta_n_r      <= 1'b0;
                  lock_n_r      <= 1'b0;
`ifdef INTA_MCS80_MODE_EN
                  mode_r        <= bus.mcs80_mode;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            ACK_LOW: begin
               if (pulse_done_s) begin
                  inta_n_r <= 1'b1;
                  if (sample_fail_s) begin
                     error_r       <= 1'b1;
                     lock_n_r      <= 1'b1;
                     pulse_index_r <= 2'd0;
                     state_r       <= IDLE;
                  end else begin
                     if (sample_pulse_s) begin
`ifdef INTA_MCS80_MODE_EN
                        if (mode_r) begin
                           case (pulse_index_r)
                              2'd2:    call_address_r[7:0]  <= bus.data_bus_in;
                              2'd3:    call_address_r[15:8] <= bus.data_bus_in;
                              default: call_address_r       <= call_address_r;
                           endcase
                        end else begin
                           vector_r <= bus.data_bus_in;
                        end
`else
                        vector_r <= bus.data_bus_in;
`endif
                     end
                     if (last_pulse_s) begin
                        state_r       <= HOLD;
                        lock_n_r      <= 1'b1;
                        valid_r       <= 1'b1;
                        pulse_index_r <= 2'd0;
                     end else begin
                        state_r <= ACK_GAP;
                     end
                  end
               end else begin
                  state_r <= ACK_LOW;
               end
            end
            ACK_GAP: begin
               if (gap_done_s) begin
                  state_r       <= ACK_LOW;
                  inta_n_r      <= 1'b0;
                  pulse_index_r <= pulse_index_r + 2'd1;
               end else begin
                  state_r <= ACK_GAP;
               end
            end
            HOLD: begin
               if (bus.vector_taken) begin
                  valid_r <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               state_r  <= IDLE;
               inta_n_r <= 1'b1;
               lock_n_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.interrupt_acknowledge_n = inta_n_r;
   assign bus.bus_lock_n              = lock_n_r;
   assign bus.vector_valid            = valid_r;
   assign bus.vector                  = vector_r;
   assign bus.bus_error               = error_r;
`ifdef INTA_MCS80_MODE_EN
   assign bus.call_address            = call_address_r;
`endif

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Self-checking bench for cpu_inta_sequencer: directed scenarios followed by
// randomized traffic, all compared against a timeline-based reference model.
// CALL-mode scenarios are included when INTA_MCS80_MODE_EN is defined.
module tb_cpu_inta_sequencer;

   localparam int P = 2;   // low clocks per pulse
   localparam int G = 1;   // high clocks between pulses

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   cpu_inta_sequencer_if bus_if ();

   cpu_inta_sequencer #(
      .INTA_PULSE_CYCLES (P),
      .INTA_GAP_CYCLES   (G)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: a sequence is described by the number of clocks since
   // it started; pulse number and phase come from division by P+G.
   bit          m_busy, m_hold, m_valid, m_err, m_mode;
   int          m_t, m_n, m_edges;
   logic [7:0]  m_vector;
   logic [15:0] m_ca;

   // Observation counters for the directed scenarios.
   int low_cycles, falls, lock_low_cycles, err_cycles, valid_cycles;
   bit prev_inta_n;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_hold = 0; m_valid = 0; m_err = 0; m_mode = 0;
      m_t = 0; m_n = 2; m_edges = 0;
      m_vector = 8'h00; m_ca = 16'h0000;
   endtask

   task automatic model_step(input bit intr, input bit ie, input logic [7:0] data,
                             input bit drv, input bit taken, input bit mode);
      int  edge_no, k, w;
      bit  last_low, sampled;
      edge_no = m_edges + 1;
      m_edges = edge_no;
      m_err   = 0;
      if (m_busy) begin
         k        = m_t / (P + G);
         w        = m_t % (P + G);
         last_low = (w == P - 1);
         sampled  = m_mode ? 1'b1 : (k == 1);
         if (last_low && sampled) begin
            if (!drv || (m_mode && k == 0 && data != 8'hCD)) begin
               m_busy = 0;
               m_err  = 1;
            end else if (!m_mode) begin
               m_vector = data;
            end else if (k == 1) begin
               m_ca[7:0] = data;
            end else if (k == 2) begin
               m_ca[15:8] = data;
            end
         end
         if (m_busy && last_low && k == m_n - 1) begin
            m_busy  = 0;
            m_hold  = 1;
            m_valid = 1;
         end else if (m_busy) begin
            m_t++;
         end
      end else if (m_hold) begin
         if (taken) begin
            m_hold  = 0;
            m_valid = 0;
         end
      end else if (intr && ie && edge_no >= 2) begin
         m_busy = 1;
         m_t    = 0;
         m_mode = mode;
         m_n    = mode ? 3 : 2;
      end
   endtask

   function automatic bit exp_inta_n();
      return !(m_busy && ((m_t % (P + G)) < P));
   endfunction

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input bit intr, input bit ie, input logic [7:0] data,
                       input bit drv, input bit taken, input bit mode);
      bus_if.interrupt_to_cpu     = intr;
      bus_if.cpu_interrupt_enable = ie;
      bus_if.data_bus_in          = data;
      bus_if.data_bus_drive       = drv;
      bus_if.vector_taken         = taken;
`ifdef INTA_MCS80_MODE_EN
      bus_if.mcs80_mode           = mode;
`endif
      model_step(intr, ie, data, drv, taken, mode);
      @(posedge clock);
      #1;
      check_value("inta_n", 32'(bus_if.interrupt_acknowledge_n), 32'(exp_inta_n()));
      check_value("lock_n", 32'(bus_if.bus_lock_n), 32'(!m_busy));
      check_value("valid", 32'(bus_if.vector_valid), 32'(m_valid));
      check_value("vector", 32'(bus_if.vector), 32'(m_vector));
      check_value("bus_error", 32'(bus_if.bus_error), 32'(m_err));
`ifdef INTA_MCS80_MODE_EN
      check_value("call_address", 32'(bus_if.call_address), 32'(m_ca));
`endif
      if (!bus_if.interrupt_acknowledge_n) low_cycles++;
      if (prev_inta_n && !bus_if.interrupt_acknowledge_n) falls++;
      if (!bus_if.bus_lock_n) lock_low_cycles++;
      if (bus_if.bus_error) err_cycles++;
      if (bus_if.vector_valid) valid_cycles++;
      prev_inta_n = bus_if.interrupt_acknowledge_n;
   endtask

   task automatic clear_counters();
      low_cycles = 0; falls = 0; lock_low_cycles = 0; err_cycles = 0; valid_cycles = 0;
      prev_inta_n = bus_if.interrupt_acknowledge_n;
   endtask

   // Assert reset between edges, check it takes effect immediately, release.
   task automatic apply_reset();
      #2 reset_n = 1'b0;
      #1;
      check_value("rst_inta_n", 32'(bus_if.interrupt_acknowledge_n), 32'd1);
      check_value("rst_lock_n", 32'(bus_if.bus_lock_n), 32'd1);
      check_value("rst_valid", 32'(bus_if.vector_valid), 32'd0);
      check_value("rst_vector", 32'(bus_if.vector), 32'h00);
      check_value("rst_bus_error", 32'(bus_if.bus_error), 32'd0);
`ifdef INTA_MCS80_MODE_EN
      check_value("rst_call_address", 32'(bus_if.call_address), 32'h0000);
`endif
      bus_if.interrupt_to_cpu     = 1'b0;
      bus_if.cpu_interrupt_enable = 1'b0;
      bus_if.data_bus_in          = 8'h00;
      bus_if.data_bus_drive       = 1'b0;
      bus_if.vector_taken         = 1'b0;
`ifdef INTA_MCS80_MODE_EN
      bus_if.mcs80_mode           = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] seq_bytes [12];
      bit         r_intr, r_ie, r_drv, r_taken, r_mode;
      logic [7:0] r_data;

      model_reset();
      apply_reset();

      // Normal 8086 sequence delivering 8'h4A.
      clear_counters();
      repeat (8) step(1'b1, 1'b1, 8'h4A, 1'b1, 1'b0, 1'b0);
      check_value("seq_vector", 32'(bus_if.vector), 32'h4A);
      check_value("seq_valid_held", 32'(bus_if.vector_valid), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check_value("seq_low_cycles", 32'(low_cycles), 32'(2 * P));
      check_value("seq_pulses", 32'(falls), 32'd2);
      check_value("seq_valid_dropped", 32'(bus_if.vector_valid), 32'd0);

      // Request with interrupts disabled never acknowledges.
      clear_counters();
      repeat (20) step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
      check_value("noif_low_cycles", 32'(low_cycles), 32'd0);
      check_value("noif_lock_cycles", 32'(lock_low_cycles), 32'd0);

      // Controller not driving on pulse 2: one error pulse, no vector.
      clear_counters();
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      repeat (9) step(1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
      check_value("nodrv_err_cycles", 32'(err_cycles), 32'd1);
      check_value("nodrv_valid_cycles", 32'(valid_cycles), 32'd0);
      check_value("nodrv_pulses", 32'(falls), 32'd2);

      // Reset in the second low cycle of pulse 1.
      apply_reset();
      step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      check_value("midrst_low_before", 32'(bus_if.interrupt_acknowledge_n), 32'd0);
      apply_reset();
      repeat (4) step(1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0);

`ifdef INTA_MCS80_MODE_EN
      // CALL mode: CD / 34 / 12 builds 16'h1234, vector untouched.
      apply_reset();
      seq_bytes = '{8'h00, 8'h00, 8'h00, 8'hCD, 8'h00, 8'h00,
                    8'h34, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00};
      clear_counters();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, seq_bytes[i], 1'b1, 1'b0, 1'b1);
      check_value("mcs_call_address", 32'(bus_if.call_address), 32'h1234);
      check_value("mcs_vector", 32'(bus_if.vector), 32'h00);
      check_value("mcs_pulses", 32'(falls), 32'd3);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      // Wrong opcode on pulse 1 aborts.
      apply_reset();
      seq_bytes[3] = 8'hC3;
      clear_counters();
      for (int i = 0; i < 12; i++) step(i < 2, 1'b1, seq_bytes[i], 1'b1, 1'b0, 1'b1);
      check_value("mcs_bad_err", 32'(err_cycles), 32'd1);
      check_value("mcs_bad_pulses", 32'(falls), 32'd1);
      check_value("mcs_bad_valid", 32'(valid_cycles), 32'd0);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r_intr  = ($urandom_range(0, 3) != 0);
         r_ie    = ($urandom_range(0, 3) != 0);
         r_drv   = ($urandom_range(0, 9) != 0);
         r_taken = ($urandom_range(0, 2) == 0);
`ifdef INTA_MCS80_MODE_EN
         r_mode  = 1'($urandom_range(0, 1));
`else
         r_mode  = 1'b0;
`endif
         r_data  = ($urandom_range(0, 1) != 0) ? 8'hCD : 8'($urandom);
         step(r_intr, r_ie, r_data, r_drv, r_taken, r_mode);
         if ($urandom_range(0, 399) == 0) apply_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
